// File: rtl/divisor_secuencial_pkg.sv
// Shared definitions for the sequential divider lesson block: state encoding
// and default operand widths.
package divisor_secuencial_pkg;

  localparam int WN_DEF = 8;
  localparam int WD_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_secuencial_resta.sv
// Combinational trial subtractor for the restoring divider: unsigned
// difference plus borrow (borrow = 1 when minuendo < sustraendo).
module resta_prueba #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuendo,
  input  logic [W-1:0] sustraendo,
  output logic [W-1:0] diferencia,
  output logic         prestamo
);

  assign {prestamo, diferencia} = {1'b0, minuendo} - {1'b0, sustraendo};

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Divide by zero finishes after one busy cycle.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one restoring step per cycle (or single zero-divisor cycle)
// S_DONE | results valid, done pulse; start here is accepted back-to-back
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          div_zero
);

  localparam int CNT_W = (WN > 1) ? $clog2(WN) : 1;

  estado_t state, nextState;

  logic [WN-1:0]    dvdReg;
  logic [WD-1:0]    dvsReg;
  logic [WD-1:0]    partRem;
  logic [WN-1:0]    quoReg;
  logic [CNT_W-1:0] bitCnt;
  logic             busyReg;
  logic             doneReg;
  logic [WN-1:0]    quoOut;
  logic [WD-1:0]    remOut;
  logic             divZeroOut;

  logic             accept;
  logic             iterate;
  logic             finish;
  logic             zeroDiv;

  logic [WD:0]      shifted;
  logic [WD:0]      diferencia;
  logic             prestamo;
  logic [WD:0]      nextRem;
  logic [WN-1:0]    nextQuo;
  logic             unusedTop;

  assign zeroDiv = (dvsReg == '0);
  assign shifted = {partRem, dvdReg[WN-1]};

  resta_prueba #(.W(WD + 1)) uResta (
    .minuendo   (shifted),
    .sustraendo ({1'b0, dvsReg}),
    .diferencia (diferencia),
    .prestamo   (prestamo)
  );

  assign nextRem = prestamo ? shifted : diferencia;
  assign nextQuo = {quoReg[WN-2:0], ~prestamo};
  // Kept value is always below the divisor, so its top bit is always zero.
  assign unusedTop = nextRem[WD];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (zeroDiv) begin
          finish    = 1'b1;
          nextState = S_DONE;
        end else begin
          iterate = 1'b1;
          if (bitCnt == '0) begin
            finish    = 1'b1;
            nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = S_RUN;
        end else begin
          nextState = S_IDLE;
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvdReg     <= '0;
      dvsReg     <= '0;
      partRem    <= '0;
      quoReg     <= '0;
      bitCnt     <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      quoOut     <= '0;
      remOut     <= '0;
      divZeroOut <= 1'b0;
    end else begin
      doneReg <= finish;
      if (accept) begin
        dvdReg  <= dividend;
        dvsReg  <= divisor;
        partRem <= '0;
        quoReg  <= '0;
        bitCnt  <= CNT_W'(WN - 1);
        busyReg <= 1'b1;
      end
      if (iterate) begin
        dvdReg  <= {dvdReg[WN-2:0], 1'b0};
        partRem <= nextRem[WD-1:0];
        quoReg  <= nextQuo;
        bitCnt  <= bitCnt - CNT_W'(1);
      end
      if (finish) begin
        busyReg <= 1'b0;
        if (zeroDiv) begin
          // Operand register is untouched here since no step ran.
          quoOut     <= '1;
          remOut     <= dvdReg[WD-1:0];
          divZeroOut <= 1'b1;
        end else begin
          quoOut     <= nextQuo;
          remOut     <= nextRem[WD-1:0];
          divZeroOut <= 1'b0;
        end
      end
    end
  end

  assign busy      = busyReg;
  assign done      = doneReg;
  assign quotient  = quoOut;
  assign remainder = remOut;
  assign div_zero  = divZeroOut;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed and random bench for divisor_secuencial; expected results come
// from plain integer division in the bench.
module tb_divisor_secuencial;

  localparam int WN = 8;
  localparam int WD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [WN-1:0] dividend = '0;
  logic [WD-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
  logic          div_zero;

  int checks = 0;
  int failures = 0;

  divisor_secuencial #(.WN(WN), .WD(WD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_q"}, 32'(quotient), 0);
    chk({tag, "_r"}, 32'(remainder), 0);
    chk({tag, "_dz"}, 32'(div_zero), 0);
  endtask

  // One request; glitchAt >= 0 re-pulses start with other operands mid-run.
  task automatic runDiv(input logic [WN-1:0] y, input logic [WD-1:0] d, input int glitchAt);
    int busyCnt;
    int doneAt;
    int expQ, expR, expLat;
    busyCnt = 0;
    doneAt  = -1;
    expQ    = (d == 0) ? (1 << WN) - 1 : int'(y) / int'(d);
    expR    = (d == 0) ? int'(y) % (1 << WD) : int'(y) % int'(d);
    expLat  = (d == 0) ? 1 : WN;
    @(negedge clk);
    start = 1'b1; dividend = y; divisor = d;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == glitchAt) begin
        start = 1'b1; dividend = ~y; divisor = d ^ 4'h5;
      end else if (i == glitchAt + 1) begin
        start = 1'b0;
      end
      if (done) begin
        doneAt = i;
        break;
      end
      if (busy) busyCnt++;
    end
    chk("latency", 32'(doneAt), 32'(expLat));
    chk("busy_cycles", 32'(busyCnt), 32'(expLat));
    chk("busy_at_done", 32'(busy), 0);
    chk("quotient", 32'(quotient), 32'(expQ));
    chk("remainder", 32'(remainder), 32'(expR));
    chk("div_zero", 32'(div_zero), 32'(d == 0));
    if (d != 0) begin
      chk("q_times_d_plus_r", 32'(quotient) * 32'(d) + 32'(remainder), 32'(y));
      chk("r_below_d", 32'(remainder < d), 1);
    end
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 0);
  endtask

  initial begin
    int firstAt;
    int secondAt;
    int spurious;

    // Reset state
    #2;
    chkIdleOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_done", 32'(done), 0);

    runDiv(8'd63, 4'd9, -1);

    // Inverse of nine-times
    for (int x = 0; x < 16; x++) runDiv(WN'(9 * x), 4'd9, -1);
    runDiv(8'd100, 4'd7, -1);
    runDiv(8'd255, 4'd1, -1);
    runDiv(8'd5, 4'd15, -1);

    // Divide by zero, then a valid division clears the flag
    runDiv(8'd200, 4'd0, -1);
    runDiv(8'd63, 4'd9, -1);

    // Start re-pulsed mid-run with different operands
    runDiv(8'd135, 4'd9, 3);

    // Start held high across DONE
    firstAt = -1;
    secondAt = -1;
    @(negedge clk);
    start = 1'b1; dividend = 8'd63; divisor = 4'd9;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        firstAt = i;
        break;
      end
    end
    chk("b2b_first_latency", 32'(firstAt), WN);
    chk("b2b_first_q", 32'(quotient), 7);
    chk("b2b_first_r", 32'(remainder), 0);
    dividend = 8'd100; divisor = 4'd7;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      if (done) begin
        secondAt = j;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_gap", 32'(secondAt), WN + 1);
    chk("b2b_second_q", 32'(quotient), 14);
    chk("b2b_second_r", 32'(remainder), 2);
    @(negedge clk);
    chk("b2b_no_third", 32'(done), 0);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; dividend = 8'd135; divisor = 4'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chkIdleOutputs("abort");
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    chk("abort_no_done", 32'(spurious), 0);
    runDiv(8'd135, 4'd9, -1);

    // Random operands, nonzero divisor
    for (int n = 0; n < 1000; n++) begin
      runDiv(WN'($urandom_range(0, (1 << WN) - 1)), WD'($urandom_range(1, (1 << WD) - 1)), -1);
    end

    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    chk("idle_tail_no_done", 32'(spurious), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
